// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared state type, class codes
// and width/saturation helpers for perceptron_n.
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    UPD,
    INFER
  } state_t;

  localparam logic signed [1:0] POS  = 2'sb01;
  localparam logic signed [1:0] ZERO = 2'sb00;
  localparam logic signed [1:0] NEG  = 2'sb11;

  function automatic int acc_w(
    input int n_in,
    input int x_w,
    input int w_w
  );
    return w_w + x_w + $clog2(n_in + 1);
  endfunction

  function automatic longint sat_hi(input int wd);
    return (longint'(1) <<< (wd - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int wd);
    return -(longint'(1) <<< (wd - 1));
  endfunction

  function automatic longint sat(
    input longint v,
    input int     wd
  );
    if (v > sat_hi(wd)) return sat_hi(wd);
    if (v < sat_lo(wd)) return sat_lo(wd);
    return v;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// perceptron_mac: full-width dot product plus bias
// and threshold-band activation.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int X_W   = 7,
  parameter int W_W   = 12,
  parameter int THETA = 0
) (
  input  logic [N_IN*X_W-1:0]  x,
  input  logic signed [W_W-1:0] w [N_IN],
  input  logic signed [W_W-1:0] b,
  output logic signed [1:0]     tout
);

  localparam int ACC_W = acc_w(N_IN, X_W, W_W);
  localparam logic signed [ACC_W-1:0] TH =
    ACC_W'(THETA);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] wi;
  logic signed [ACC_W-1:0] xi;

  // y = b + sum w[i]*x[i], wide enough to never wrap
  always_comb begin
    acc = ACC_W'(b);
    wi  = '0;
    xi  = '0;
    for (int i = 0; i < N_IN; i++) begin
      wi  = ACC_W'(w[i]);
      xi  = ACC_W'($signed(x[i*X_W +: X_W]));
      acc = acc + wi * xi;
    end
  end

  // three-way class against the +/-THETA band
  always_comb begin
    tout = ZERO;
    if (acc > TH) begin
      tout = POS;
    end else if (acc < -TH) begin
      tout = NEG;
    end
  end

endmodule

// File: rtl/perceptron_n.sv
// perceptron_n: online-trained N-input perceptron
// with epoch control and registered inference.
module perceptron_n
  import perceptron_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int X_W       = 7,
  parameter int W_W       = 12,
  parameter int THETA     = 0,
  parameter int ALPHA_SH  = 0,
  parameter int MAX_EPOCH = 100,
  localparam int E_W = $clog2(MAX_EPOCH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [N_IN*X_W-1:0] x,
  input  logic signed [1:0]   tin,
  input  logic                eof,
  input  logic                eoi,
  output logic signed [1:0]   tout,
  output logic                out_valid,
  output logic                updating,
  output logic                learned,
  output logic                timeout,
  output logic                busy,
  output logic [E_W-1:0]      epoch
);

  state_t state, state_n;

  logic signed [W_W-1:0] w   [N_IN];
  logic signed [W_W-1:0] w_n [N_IN];
  logic signed [W_W-1:0] b, b_n;
  logic [N_IN*X_W-1:0]   xl;
  logic signed [1:0]     tl;
  logic signed [1:0]     net_t;

  logic errf, eof_q, pend;
  logic eof_rise, eof_ev;
  logic clr, lat, upd, ep_inc, err_clr;
  logic set_l, set_t, ivalid;

  longint xv, dv, bv;

  perceptron_mac #(
    .N_IN (N_IN),
    .X_W  (X_W),
    .W_W  (W_W),
    .THETA(THETA)
  ) u_mac (
    .x   (x),
    .w   (w),
    .b   (b),
    .tout(net_t)
  );

  assign eof_rise  = eof & ~eof_q;
  assign eof_ev    = eof_rise | pend;
  assign updating  = (state == UPD);
  assign busy      = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    lat     = 1'b0;
    upd     = 1'b0;
    ep_inc  = 1'b0;
    err_clr = 1'b0;
    set_l   = 1'b0;
    set_t   = 1'b0;
    ivalid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = mode ? INFER : TRAIN;
          clr     = ~mode;
        end
      end
      TRAIN: begin
        if (eof_ev) begin
          if (!errf) begin
            set_l   = 1'b1;
            state_n = IDLE;
          end else begin
            ep_inc  = 1'b1;
            err_clr = 1'b1;
            if (epoch == E_W'(MAX_EPOCH - 1)) begin
              set_t   = 1'b1;
              state_n = IDLE;
            end
          end
        end else if (net_t != tin) begin
          lat     = 1'b1;
          state_n = UPD;
        end
      end
      UPD: begin
        upd     = 1'b1;
        state_n = TRAIN;
      end
      INFER: begin
        if (eoi) state_n = IDLE;
        else     ivalid  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // saturating update from the latched sample
  always_comb begin
    xv = 0;
    dv = 0;
    for (int i = 0; i < N_IN; i++) begin
      xv = longint'($signed(xl[i*X_W +: X_W]));
      dv = (tl == NEG) ? -xv : xv;
      dv = dv >>> ALPHA_SH;
      w_n[i] = W_W'(sat(longint'(w[i]) + dv, W_W));
    end
    bv  = (tl == NEG) ? longint'(-1) : longint'(1);
    bv  = bv >>> ALPHA_SH;
    b_n = W_W'(sat(longint'(b) + bv, W_W));
  end

  // weights, flags, epoch count and inference output
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
      b         <= '0;
      xl        <= '0;
      tl        <= ZERO;
      errf      <= 1'b0;
      eof_q     <= 1'b0;
      pend      <= 1'b0;
      epoch     <= '0;
      learned   <= 1'b0;
      timeout   <= 1'b0;
      tout      <= ZERO;
      out_valid <= 1'b0;
    end else begin
      eof_q <= eof;
      pend  <= (state == UPD) & (pend | eof_rise);
      if (clr) begin
        for (int i = 0; i < N_IN; i++) w[i] <= '0;
        b       <= '0;
        epoch   <= '0;
        learned <= 1'b0;
        timeout <= 1'b0;
        errf    <= 1'b0;
      end
      if (lat) begin
        xl   <= x;
        tl   <= tin;
        errf <= 1'b1;
      end
      if (upd) begin
        for (int i = 0; i < N_IN; i++) w[i] <= w_n[i];
        b <= b_n;
      end
      if (err_clr) errf  <= 1'b0;
      if (ep_inc)  epoch <= epoch + 1'b1;
      if (set_l)   learned <= 1'b1;
      if (set_t) begin
        timeout <= 1'b1;
        learned <= 1'b0;
      end
      tout      <= ivalid ? net_t : ZERO;
      out_valid <= ivalid;
    end
  end

endmodule

// File: tb/tb_perceptron_n.sv
// tb_perceptron_n: directed checks of training,
// saturation, timeout, inference and reset.
module tb_perceptron_n;

  logic              clk = 1'b0;
  logic              rst, mode, eof, eoi;
  logic              sa, ss, st;
  logic [13:0]       x;
  logic signed [1:0] tin;

  logic signed [1:0] tout_a, tout_s, tout_t;
  logic ov_a, upd_a, lrn_a, to_a, busy_a;
  logic ov_s, upd_s, lrn_s, to_s, busy_s;
  logic ov_t, upd_t, lrn_t, to_t, busy_t;
  logic [6:0] ep_a, ep_s;
  logic [2:0] ep_t;

  int total = 0;
  int pass  = 0;
  int fails = 0;

  int sx0[4]   = '{5, 5, -5, -5};
  int sx1[4]   = '{5, -5, 5, -5};
  int and_t[4] = '{1, -1, -1, -1};
  int xor_t[4] = '{-1, 1, 1, -1};
  int sat_e[4] = '{63, 126, 127, 127};
  int nu[10]   = '{default: 0};
  int nt;

  always #5 clk = ~clk;

  perceptron_n dut_a (
    .clk(clk), .rst(rst), .start(sa), .mode(mode),
    .x(x), .tin(tin), .eof(eof), .eoi(eoi),
    .tout(tout_a), .out_valid(ov_a),
    .updating(upd_a), .learned(lrn_a),
    .timeout(to_a), .busy(busy_a), .epoch(ep_a)
  );

  perceptron_n #(.W_W(8), .THETA(20000)) dut_s (
    .clk(clk), .rst(rst), .start(ss), .mode(mode),
    .x(x), .tin(tin), .eof(eof), .eoi(eoi),
    .tout(tout_s), .out_valid(ov_s),
    .updating(upd_s), .learned(lrn_s),
    .timeout(to_s), .busy(busy_s), .epoch(ep_s)
  );

  perceptron_n #(.MAX_EPOCH(4)) dut_t (
    .clk(clk), .rst(rst), .start(st), .mode(mode),
    .x(x), .tin(tin), .eof(eof), .eoi(eoi),
    .tout(tout_t), .out_valid(ov_t),
    .updating(upd_t), .learned(lrn_t),
    .timeout(to_t), .busy(busy_t), .epoch(ep_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setx(input int a, input int c);
    x = {7'(c), 7'(a)};
  endtask

  task automatic chk(
    input string             tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    total++;
    assert (got === exp) begin
      pass++;
    end else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic train_epoch(
    input  int set,
    input  int which,
    output int n
  );
    n = 0;
    for (int i = 0; i < 4; i++) begin
      setx(sx0[i], sx1[i]);
      tin = (set == 0) ? 2'(and_t[i]) : 2'(xor_t[i]);
      tick();
      if (((which == 0) ? upd_a : upd_t) === 1'b1) begin
        n++;
        tick();
      end
    end
    eof = 1'b1;
    tick();
    eof = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mode = 1'b0; eof = 1'b0; eoi = 1'b0;
    sa = 1'b0; ss = 1'b0; st = 1'b0;
    x = '0; tin = 2'sb00;
    tick();
    tick();
    chk("rst_tout", tout_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_upd", upd_a, 0);
    chk("rst_lrn", lrn_a, 0);
    chk("rst_to", to_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ep", ep_a, 0);
    chk("rst_w0", dut_a.w[0], 0);
    rst = 1'b0;

    // single update from zero weights
    sa = 1'b1; mode = 1'b0;
    tick();
    chk("t1_busy", busy_a, 1);
    sa = 1'b0;
    setx(3, -2); tin = 2'sb01;
    tick();
    chk("t1_upd", upd_a, 1);
    chk("t1_w0_pre", dut_a.w[0], 0);
    tick();
    chk("t1_upd_lo", upd_a, 0);
    chk("t1_w0", dut_a.w[0], 3);
    chk("t1_w1", dut_a.w[1], -2);
    chk("t1_b", dut_a.b, 1);
    tick();
    chk("t1_noupd", upd_a, 0);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    chk("t1_ep", ep_a, 1);
    chk("t1_busy2", busy_a, 1);
    tick();
    eof = 1'b1;
    tick();
    eof = 1'b0;
    chk("t1_lrn", lrn_a, 1);
    chk("t1_busy_lo", busy_a, 0);
    chk("t1_to", to_a, 0);

    // AND convergence
    sa = 1'b1; mode = 1'b0;
    tick();
    sa = 1'b0;
    chk("and_lrn_clr", lrn_a, 0);
    chk("and_ep_clr", ep_a, 0);
    chk("and_w_clr", dut_a.w[0], 0);
    for (int e = 0; e < 10; e++) begin
      if (busy_a !== 1'b1) break;
      train_epoch(0, 0, nu[e]);
    end
    chk("and_ep1_upd", nu[0], 3);
    chk("and_ep2_upd", nu[1], 0);
    chk("and_lrn", lrn_a, 1);
    chk("and_to", to_a, 0);
    chk("and_busy", busy_a, 0);
    chk("and_ep", ep_a, 1);
    chk("and_w0", dut_a.w[0], 5);
    chk("and_w1", dut_a.w[1], 5);
    chk("and_b", dut_a.b, -1);

    // inference with the learned weights
    sa = 1'b1; mode = 1'b1;
    tick();
    sa = 1'b0;
    chk("inf_busy", busy_a, 1);
    chk("inf_ov0", ov_a, 0);
    setx(5, 5);
    tick();
    chk("inf_pp", tout_a, 1);
    chk("inf_pp_ov", ov_a, 1);
    setx(-5, -5);
    tick();
    chk("inf_nn", tout_a, -1);
    chk("inf_nn_ov", ov_a, 1);
    setx(5, -5);
    tick();
    chk("inf_pn", tout_a, -1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("inf_busy_lo", busy_a, 0);
    chk("inf_ov_lo", ov_a, 0);
    chk("inf_lrn_kept", lrn_a, 1);

    // XOR never converges: epoch limit 4
    st = 1'b1; mode = 1'b0;
    tick();
    st = 1'b0;
    repeat (3) train_epoch(1, 1, nt);
    chk("xor_ep3", ep_t, 3);
    chk("xor_busy3", busy_t, 1);
    train_epoch(1, 1, nt);
    chk("xor_to", to_t, 1);
    chk("xor_lrn", lrn_t, 0);
    chk("xor_ep4", ep_t, 4);
    chk("xor_busy", busy_t, 0);

    // saturation with a band nothing can leave
    ss = 1'b1; mode = 1'b0;
    tick();
    ss = 1'b0;
    setx(63, 63); tin = 2'sb01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_upd", upd_s, 1);
      tick();
      chk("sat_w0", dut_s.w[0], sat_e[k]);
    end
    chk("sat_w1", dut_s.w[1], 127);
    chk("sat_b", dut_s.b, 4);

    // start while busy ignored, reset during UPD
    sa = 1'b1; mode = 1'b0;
    tick();
    setx(3, -2); tin = 2'sb01;
    sa = 1'b1; mode = 1'b1;
    tick();
    sa = 1'b0;
    chk("rs_upd", upd_a, 1);
    chk("rs_ov", ov_a, 0);
    rst = 1'b1;
    tick();
    chk("rs_tout", tout_a, 0);
    chk("rs_ov2", ov_a, 0);
    chk("rs_upd2", upd_a, 0);
    chk("rs_lrn", lrn_a, 0);
    chk("rs_to", to_a, 0);
    chk("rs_busy", busy_a, 0);
    chk("rs_ep", ep_a, 0);
    chk("rs_w0", dut_a.w[0], 0);
    chk("rs_w1", dut_a.w[1], 0);
    chk("rs_b", dut_a.b, 0);
    chk("rs_s_w0", dut_s.w[0], 0);
    chk("rs_t_to", to_t, 0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
